// File: rtl/poly_tone_gen_if.sv
// poly_tone_gen_if: key/octave inputs and mixed audio outputs of the polyphonic tone generator.
interface poly_tone_gen_if #(
    parameter int NUM_VOICES = 4
);
    localparam int LW = $clog2(NUM_VOICES + 1);
    logic [11:0]           keys;
    logic [3:0]            octave;
    logic                  sustain;
    logic                  audio_pdm;
    logic [LW-1:0]         audio_level;
    logic [NUM_VOICES-1:0] voice_active;
    logic                  keys_dropped;
    modport master (output keys, octave, sustain, input audio_pdm, audio_level, voice_active, keys_dropped);
    modport slave (input keys, octave, sustain, output audio_pdm, audio_level, voice_active, keys_dropped);
endinterface

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: 12-key polyphonic square-wave generator with level mixer and sigma-delta output.
// Optional sustain pedal behaviour is enabled by defining SUSTAIN_EN.
module poly_tone_gen #(
    parameter int CLK_HZ     = 1_000_000,
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 16,
    parameter int OCT_MAX    = 8
) (
    input logic clk,
    input logic rst_n,
    poly_tone_gen_if.slave bus
);
    localparam int LW = $clog2(NUM_VOICES + 1);
    localparam int AW = $clog2(NUM_VOICES) + 2;
    typedef enum logic {IDLE, RUN} vst_t;

    function automatic logic [DIV_W-1:0] bh(input int f);
        return DIV_W'(64'(CLK_HZ) * 50 / f);
    endfunction

    // index 0 is B (keys[0]) up to index 11 C (keys[11])
    localparam logic [DIV_W-1:0] BASE [12] = '{bh(3087), bh(2914), bh(2750), bh(2596), bh(2450), bh(2312),
                                               bh(2183), bh(2060), bh(1945), bh(1835), bh(1732), bh(1635)};

    logic [11:0]           keys_m, keys_s, eff;
    logic [3:0]            oct_m, oct_s, oct_c, oct_a, poct;
    logic [3:0]            a_key [NUM_VOICES];
    logic [3:0]            vkey [NUM_VOICES];
    logic [3:0]            pkey [NUM_VOICES];
    logic [NUM_VOICES-1:0] a_val, vval, vout, out_n, load, act;
    logic                  dropped, pdm;
    logic [LW-1:0]         level;
    logic [AW-1:0]         acc, sum;
    logic [DIV_W-1:0]      half [NUM_VOICES];
    logic [DIV_W-1:0]      cnt [NUM_VOICES];
    logic [DIV_W-1:0]      cnt_n [NUM_VOICES];
    vst_t                  st [NUM_VOICES];
    vst_t                  st_n [NUM_VOICES];
    int                    pop;

    assign oct_c = oct_s > 4'(OCT_MAX) ? 4'(OCT_MAX) : oct_s;

`ifdef SUSTAIN_EN
    logic       sus_m, sus_s;
    logic [11:0] a_mask, amask;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sus_m <= 1'b0;
            sus_s <= 1'b0;
            amask <= '0;
        end else begin
            sus_m <= bus.sustain;
            sus_s <= sus_m;
            amask <= a_mask;
        end
    // released keys stay in the candidate set while the pedal is down
    assign eff = keys_s | (sus_s ? amask : 12'h0);
`else
    logic unused_sustain;
    assign unused_sustain = bus.sustain;
    assign eff = keys_s;
`endif

    always_comb begin
        pop = 0;
        a_key = '{default: '0};
        a_val = '0;
`ifdef SUSTAIN_EN
        a_mask = '0;
`endif
        for (int k = 11; k >= 0; k--)
            if (eff[k]) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (pop == v) begin
                        a_key[v] = 4'(k);
                        a_val[v] = 1'b1;
                    end
`ifdef SUSTAIN_EN
                if (pop < NUM_VOICES) a_mask[k] = 1'b1;
`endif
                pop++;
            end
    end

    assign sum = acc + AW'(level);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            keys_m  <= '0;
            keys_s  <= '0;
            oct_m   <= '0;
            oct_s   <= '0;
            oct_a   <= '0;
            vkey    <= '{default: '0};
            vval    <= '0;
            dropped <= 1'b0;
            level   <= '0;
            acc     <= '0;
            pdm     <= 1'b0;
        end else begin
            keys_m  <= bus.keys;
            keys_s  <= keys_m;
            oct_m   <= bus.octave;
            oct_s   <= oct_m;
            oct_a   <= oct_c;
            vkey    <= a_key;
            vval    <= a_val;
            dropped <= pop > NUM_VOICES;
            level   <= LW'($countones(vout));
            acc     <= sum >= AW'(NUM_VOICES) ? sum - AW'(NUM_VOICES) : sum;
            pdm     <= sum >= AW'(NUM_VOICES);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st   <= '{default: IDLE};
            cnt  <= '{default: '0};
            pkey <= '{default: '0};
            vout <= '0;
            poct <= '0;
        end else begin
            st   <= st_n;
            cnt  <= cnt_n;
            pkey <= vkey;
            vout <= out_n;
            poct <= oct_a;
        end

    // oct_a travels with the allocation so a key and octave change land on one reload
    always_comb
        for (int v = 0; v < NUM_VOICES; v++) begin
            half[v]  = (BASE[vkey[v]] >> oct_a) == '0 ? DIV_W'(1) : BASE[vkey[v]] >> oct_a;
            load[v]  = vval[v] && (st[v] == IDLE || vkey[v] != pkey[v] || oct_a != poct);
            st_n[v]  = vval[v] ? RUN : IDLE;
            cnt_n[v] = !vval[v] ? '0 : (load[v] || cnt[v] == '0) ? half[v] - 1'b1 : cnt[v] - 1'b1;
            out_n[v] = vval[v] && (load[v] || (cnt[v] == '0 ? ~vout[v] : vout[v]));
            act[v]   = st[v] == RUN;
        end

    assign bus.audio_pdm    = pdm;
    assign bus.audio_level  = level;
    assign bus.voice_active = act;
    assign bus.keys_dropped = dropped;
endmodule
